// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: command, ALU pin and response bundle for alu_op_issuer
//   master: issuer side (takes commands, drives ALU pins, returns responses)
//   slave : environment side (issues commands, models ALU, consumes responses)
//   ALU_ISSUER_ZFLAG_EN adds rsp_zero
interface alu_op_issuer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_ci;
   logic [2:0]  cmd_f;
   logic [1:0]  cmd_dir;
   logic [4:0]  cmd_bite;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_ci;
   logic [2:0]  alu_f;
   logic [1:0]  alu_dir;
   logic [4:0]  alu_bite;
   logic [31:0] alu_s;
   logic        alu_co;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_s;
   logic        rsp_co;
   logic [2:0]  rsp_f;
`ifdef ALU_ISSUER_ZFLAG_EN
   logic        rsp_zero;
   modport master (
      input  cmd_valid, cmd_a, cmd_b, cmd_ci, cmd_f, cmd_dir, cmd_bite, alu_s, alu_co, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite, rsp_valid, rsp_s, rsp_co, rsp_f, rsp_zero
   );
   modport slave (
      output cmd_valid, cmd_a, cmd_b, cmd_ci, cmd_f, cmd_dir, cmd_bite, alu_s, alu_co, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite, rsp_valid, rsp_s, rsp_co, rsp_f, rsp_zero
   );
`else
   modport master (
      input  cmd_valid, cmd_a, cmd_b, cmd_ci, cmd_f, cmd_dir, cmd_bite, alu_s, alu_co, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite, rsp_valid, rsp_s, rsp_co, rsp_f
   );
   modport slave (
      output cmd_valid, cmd_a, cmd_b, cmd_ci, cmd_f, cmd_dir, cmd_bite, alu_s, alu_co, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite, rsp_valid, rsp_s, rsp_co, rsp_f
   );
`endif
endinterface

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one ALU operation at a time, waits SETTLE_CYCLES, returns S/CO
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_op_issuer_if.master (cmd valid/ready in, alu_* pins out, rsp valid/ready out)
//   ALU_ISSUER_ZFLAG_EN adds rsp_zero = (captured S == 0)
module alu_op_issuer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic clk,
   input logic rst,
   alu_op_issuer_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic        alu_ci_q, alu_ci_d;
   logic [2:0]  alu_f_q, alu_f_d;
   logic [1:0]  alu_dir_q, alu_dir_d;
   logic [4:0]  alu_bite_q, alu_bite_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_s_q, rsp_s_d;
   logic        rsp_co_q, rsp_co_d;
   logic [2:0]  rsp_f_q, rsp_f_d;
`ifdef ALU_ISSUER_ZFLAG_EN
   logic        rsp_zero_q, rsp_zero_d;
   assign bus.rsp_zero = rsp_zero_q;
`endif
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_ci_d    = alu_ci_q;
      alu_f_d     = alu_f_q;
      alu_dir_d   = alu_dir_q;
      alu_bite_d  = alu_bite_q;
      rsp_valid_d = rsp_valid_q;
      rsp_s_d     = rsp_s_q;
      rsp_co_d    = rsp_co_q;
      rsp_f_d     = rsp_f_q;
`ifdef ALU_ISSUER_ZFLAG_EN
      rsp_zero_d  = rsp_zero_q;
`endif
      if (state_q == IDLE && bus.cmd_valid && cmd_ready_q) begin
         alu_a_d    = bus.cmd_a;
         alu_b_d    = bus.cmd_b;
         alu_ci_d   = bus.cmd_ci;
         alu_f_d    = bus.cmd_f;
         alu_dir_d  = bus.cmd_dir;
         alu_bite_d = bus.cmd_bite;
         cnt_d      = CNT_INIT;
         state_d    = SETTLE;
      end else if (state_q == SETTLE) begin
         if (cnt_q == 4'd0) begin
            rsp_s_d     = bus.alu_s;
            rsp_co_d    = (alu_f_q == 3'b001) ? bus.alu_co : 1'b0;
            rsp_f_d     = alu_f_q;
`ifdef ALU_ISSUER_ZFLAG_EN
            rsp_zero_d  = (bus.alu_s == 32'd0);
`endif
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (state_q == RESP && bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
         state_d     = IDLE;
      end
      // ready is registered, so it is derived from the state being entered
      cmd_ready_d = (state_d == IDLE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ci_q    <= 1'b0;
         alu_f_q     <= '0;
         alu_dir_q   <= '0;
         alu_bite_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_s_q     <= '0;
         rsp_co_q    <= 1'b0;
         rsp_f_q     <= '0;
`ifdef ALU_ISSUER_ZFLAG_EN
         rsp_zero_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ci_q    <= alu_ci_d;
         alu_f_q     <= alu_f_d;
         alu_dir_q   <= alu_dir_d;
         alu_bite_q  <= alu_bite_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_s_q     <= rsp_s_d;
         rsp_co_q    <= rsp_co_d;
         rsp_f_q     <= rsp_f_d;
`ifdef ALU_ISSUER_ZFLAG_EN
         rsp_zero_q  <= rsp_zero_d;
`endif
      end
   end
   assign bus.cmd_ready = cmd_ready_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_ci    = alu_ci_q;
   assign bus.alu_f     = alu_f_q;
   assign bus.alu_dir   = alu_dir_q;
   assign bus.alu_bite  = alu_bite_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_s     = rsp_s_q;
   assign bus.rsp_co    = rsp_co_q;
   assign bus.rsp_f     = rsp_f_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed self-checking bench for alu_op_issuer (SETTLE_CYCLES 1 and 4)
module tb_alu_op_issuer;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic        ovr_en;
   logic [31:0] ovr_val;
   alu_op_issuer_if b1 ();
   alu_op_issuer_if b4 ();
   alu_op_issuer #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   alu_op_issuer #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
   always #5 clk = ~clk;
   // ALU model: CO is a true carry only for add; other functions drive CO high so gating is visible
   function automatic logic [32:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic ci);
      case (f)
         3'b000:  alu_fn = {1'b1, 32'hFFFF_FFFF};
         3'b001:  alu_fn = 33'(a) + 33'(b) + 33'(ci);
         3'b100:  alu_fn = {1'b1, a & b};
         3'b101:  alu_fn = {1'b1, a | b};
         3'b110:  alu_fn = {1'b1, ~a};
         3'b111:  alu_fn = {1'b1, a ^ b};
         default: alu_fn = {1'b1, a};
      endcase
   endfunction
   logic [32:0] m1, m4;
   assign m1 = alu_fn(b1.alu_f, b1.alu_a, b1.alu_b, b1.alu_ci);
   assign m4 = alu_fn(b4.alu_f, b4.alu_a, b4.alu_b, b4.alu_ci);
   assign b1.alu_s  = m1[31:0];
   assign b1.alu_co = m1[32];
   assign b4.alu_s  = ovr_en ? ovr_val : m4[31:0];
   assign b4.alu_co = m4[32];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic [2:0] f);
      b1.cmd_a = a;
      b1.cmd_b = b;
      b1.cmd_ci = ci;
      b1.cmd_f = f;
      b1.cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !b1.cmd_ready; i++) @(negedge clk);
      if (!b1.cmd_ready) chk("accept_timeout", 0, 1);
      @(negedge clk);
      b1.cmd_valid = 1'b0;
   endtask
   task automatic wait_rsp1();
      for (int i = 0; i < 20 && !b1.rsp_valid; i++) @(negedge clk);
      if (!b1.rsp_valid) chk("rsp_timeout", 0, 1);
   endtask
   task automatic op1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic [2:0] f, input logic [31:0] s, input logic co);
      send1(a, b, ci, f);
      wait_rsp1();
      chk({tag, "_s"}, 64'(b1.rsp_s), 64'(s));
      chk({tag, "_co"}, 64'(b1.rsp_co), 64'(co));
      chk({tag, "_f"}, 64'(b1.rsp_f), 64'(f));
`ifdef ALU_ISSUER_ZFLAG_EN
      chk({tag, "_zero"}, 64'(b1.rsp_zero), 64'(s == 32'd0));
`endif
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic        seen;
      logic        take;
      int          k;
      int          r;
      int          acc_e [3];
      logic [31:0] qa [3];
      logic [31:0] qb [3];
      qa = '{32'd10, 32'd20, 32'd30};
      qb = '{32'd1, 32'd2, 32'd3};
      rst = 1'b1;
      ovr_en = 1'b0;
      ovr_val = '0;
      {b1.cmd_valid, b1.cmd_a, b1.cmd_b, b1.cmd_ci, b1.cmd_f, b1.cmd_dir, b1.cmd_bite, b1.rsp_ready} = '0;
      {b4.cmd_valid, b4.cmd_a, b4.cmd_b, b4.cmd_ci, b4.cmd_f, b4.cmd_dir, b4.cmd_bite, b4.rsp_ready} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 64'(b1.cmd_ready), 0);
      chk("rst_rsp_valid", 64'(b1.rsp_valid), 0);
      chk("rst_alu_a", 64'(b1.alu_a), 0);
      rst = 1'b0;
      b1.rsp_ready = 1'b1;
      b4.rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(b1.cmd_ready), 1);
      // first op with exact edge timing
      b1.cmd_a = 32'd5;
      b1.cmd_b = 32'd7;
      b1.cmd_f = 3'b001;
      b1.cmd_dir = 2'd2;
      b1.cmd_bite = 5'd17;
      b1.cmd_valid = 1'b1;
      @(negedge clk);
      b1.cmd_valid = 1'b0;
      chk("e0_ready", 64'(b1.cmd_ready), 0);
      chk("e0_valid", 64'(b1.rsp_valid), 0);
      chk("e0_alu_a", 64'(b1.alu_a), 5);
      chk("e0_alu_dir", 64'(b1.alu_dir), 2);
      chk("e0_alu_bite", 64'(b1.alu_bite), 17);
      @(negedge clk);
      chk("e1_valid", 64'(b1.rsp_valid), 1);
      chk("e1_s", 64'(b1.rsp_s), 12);
      chk("e1_co", 64'(b1.rsp_co), 0);
      chk("e1_f", 64'(b1.rsp_f), 1);
      @(negedge clk);
      chk("e2_valid", 64'(b1.rsp_valid), 0);
      chk("e2_ready", 64'(b1.cmd_ready), 1);
      chk("e2_s_hold", 64'(b1.rsp_s), 12);
      chk("e2_alu_hold", 64'(b1.alu_a), 5);
      b1.cmd_dir = 2'd0;
      b1.cmd_bite = 5'd0;
      op1("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b001, 32'd0, 1'b1);
      op1("xor", 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 3'b111, 32'h0F0F_F0F0, 1'b0);
      op1("addci", 32'd1, 32'd2, 1'b1, 3'b001, 32'd4, 1'b0);
      op1("not", 32'h1234_5678, 32'd0, 1'b0, 3'b110, 32'hEDCB_A987, 1'b0);
      op1("and", 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 3'b100, 32'h0F00_0F00, 1'b0);
      op1("or", 32'hFF00_0000, 32'h0000_00FF, 1'b0, 3'b101, 32'hFF00_00FF, 1'b0);
      op1("ones", 32'd0, 32'd0, 1'b0, 3'b000, 32'hFFFF_FFFF, 1'b0);
      // backpressure
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      send1(32'd3, 32'd4, 1'b0, 3'b001);
      wait_rsp1();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(b1.rsp_valid), 1);
         chk("bp_s", 64'(b1.rsp_s), 7);
         chk("bp_co", 64'(b1.rsp_co), 0);
         chk("bp_ready", 64'(b1.cmd_ready), 0);
         b1.cmd_a = 32'd99;
         b1.cmd_valid = (i == 2);
         @(negedge clk);
      end
      b1.cmd_valid = 1'b0;
      b1.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_done_valid", 64'(b1.rsp_valid), 0);
      chk("bp_not_latched", 64'(b1.alu_a), 3);
      @(negedge clk);
      chk("bp_ready_back", 64'(b1.cmd_ready), 1);
      // back-to-back, three queued commands
      k = 0;
      r = 0;
      acc_e = '{0, 0, 0};
      b1.cmd_a = qa[0];
      b1.cmd_b = qb[0];
      b1.cmd_f = 3'b001;
      b1.cmd_valid = 1'b1;
      for (int e = 0; e < 12; e++) begin
         if (b1.rsp_valid) begin
            if (r < 3) chk("b2b_s", 64'(b1.rsp_s), 64'(qa[r] + qb[r]));
            r++;
         end
         take = b1.cmd_valid && b1.cmd_ready;
         @(negedge clk);
         if (take) begin
            acc_e[k] = e;
            k++;
            if (k < 3) begin
               b1.cmd_a = qa[k];
               b1.cmd_b = qb[k];
            end else b1.cmd_valid = 1'b0;
         end
      end
      chk("b2b_accepts", 64'(k), 3);
      chk("b2b_rsps", 64'(r), 3);
      chk("b2b_e1", 64'(acc_e[1] - acc_e[0]), 3);
      chk("b2b_e2", 64'(acc_e[2] - acc_e[0]), 6);
      // SETTLE_CYCLES=4: hold and late capture
      b4.cmd_a = 32'd100;
      b4.cmd_b = 32'd23;
      b4.cmd_f = 3'b001;
      b4.cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !b4.cmd_ready; i++) @(negedge clk);
      @(negedge clk);
      b4.cmd_valid = 1'b0;
      chk("s4_e0_alu_a", 64'(b4.alu_a), 100);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("s4_alu_a", 64'(b4.alu_a), 100);
         chk("s4_alu_f", 64'(b4.alu_f), 1);
         chk("s4_valid", 64'(b4.rsp_valid), 64'(i == 4));
         if (i == 2) begin
            ovr_val = 32'hDEAD_BEEF;
            ovr_en = 1'b1;
         end
      end
      chk("s4_s", 64'(b4.rsp_s), 64'h0000_0000_DEAD_BEEF);
      chk("s4_co", 64'(b4.rsp_co), 0);
      @(negedge clk);
      ovr_en = 1'b0;
      chk("s4_done", 64'(b4.rsp_valid), 0);
      // reset mid-SETTLE
      @(negedge clk);
      b4.cmd_a = 32'd55;
      b4.cmd_b = 32'd1;
      b4.cmd_valid = 1'b1;
      @(negedge clk);
      b4.cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rs_valid", 64'(b4.rsp_valid), 0);
      chk("rs_ready", 64'(b4.cmd_ready), 0);
      chk("rs_alu_a", 64'(b4.alu_a), 0);
      chk("rs_rsp_s", 64'(b4.rsp_s), 0);
      @(negedge clk);
      chk("rs_ready_back", 64'(b4.cmd_ready), 1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen |= b4.rsp_valid;
         @(negedge clk);
      end
      chk("rs_no_stale", 64'(seen), 0);
      // reset mid-RESP
      b1.rsp_ready = 1'b0;
      send1(32'd8, 32'd9, 1'b0, 3'b001);
      wait_rsp1();
      chk("rr_pre_s", 64'(b1.rsp_s), 17);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rr_valid", 64'(b1.rsp_valid), 0);
      chk("rr_rsp_s", 64'(b1.rsp_s), 0);
      chk("rr_rsp_f", 64'(b1.rsp_f), 0);
      chk("rr_alu_a", 64'(b1.alu_a), 0);
      chk("rr_ready", 64'(b1.cmd_ready), 0);
      @(negedge clk);
      chk("rr_ready_back", 64'(b1.cmd_ready), 1);
      b1.rsp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen |= b1.rsp_valid;
         @(negedge clk);
      end
      chk("rr_no_stale", 64'(seen), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
